// File: rtl/rca_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rca_pkg
// Description : Shared constants, state encoding and helpers for the
//               nibble-serial adder built around the 4-bit rca.
// Contents    : NIB_W       - nibble width handled by one rca pass
//               nsa_state_t - sequencer states (IDLE, RUN, DONE)
//               nib_count   - number of nibbles in a WIDTH-bit operand
// Revision    : 1.0 - initial release
// ============================================================================
package rca_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nsa_state_t;

  function automatic int nib_count(input int width);
    return width / NIB_W;
  endfunction

endpackage : rca_pkg
`default_nettype wire

// File: rtl/rca.sv
`default_nettype none
// ============================================================================
// Module      : rca
// Description : Purely combinational 4-bit ripple-carry adder.
// Ports       : a    in  4  operand A
//               b    in  4  operand B
//               c    in  1  carry-in
//               y    out 4  sum
//               cout out 1  carry-out of the top bit
// Revision    : 1.0 - initial release
// ============================================================================
module rca (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c,
  output logic [3:0] y,
  output logic       cout
);

  logic [4:0] w_c;

  assign w_c[0] = c;

  for (genvar gi = 0; gi < 4; gi++) begin : g_bit
    assign y[gi]     = a[gi] ^ b[gi] ^ w_c[gi];
    assign w_c[gi+1] = (a[gi] & b[gi]) | (w_c[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = w_c[4];

endmodule : rca
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder
// Description : Multi-cycle WIDTH-bit adder. Feeds one rca instance a nibble
//               per clock, rippling the carry between cycles through a
//               register, and collects the result nibble by nibble.
// Ports       : clk    in  1      system clock, rising edge
//               reset  in  1      synchronous active-high reset
//               start  in  1      request, sampled only in IDLE
//               a_in   in  WIDTH  operand A, captured on accept
//               b_in   in  WIDTH  operand B, captured on accept
//               cin    in  1      carry-in, captured on accept
//               busy   out 1      high in RUN and DONE
//               done   out 1      one-cycle completion pulse
//               sum    out WIDTH  result, held until the next accept
//               cout   out 1      final carry-out, same validity as sum
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder
  import rca_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int c_NIB   = nib_count(WIDTH);
  localparam int c_IDX_W = (c_NIB > 1) ? $clog2(c_NIB) : 1;
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(c_NIB - 1);

  if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_width_check
    $error("nibble_serial_adder: WIDTH must be a non-zero multiple of 4");
  end

  nsa_state_t         r_state;
  logic [c_IDX_W-1:0] r_idx;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_busy;
  logic               r_done;

  logic [NIB_W-1:0]   w_y;
  logic               w_co;

  // The index is parked at 0 outside RUN, so the adder inputs stay quiet
  // while idle without needing a separate mux.
  rca u_rca (
    .a    (r_a[NIB_W*r_idx +: NIB_W]),
    .b    (r_b[NIB_W*r_idx +: NIB_W]),
    .c    (r_carry),
    .y    (w_y),
    .cout (w_co)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_carry <= cin;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sum[NIB_W*r_idx +: NIB_W] <= w_y;
          r_carry <= w_co;
          if (r_idx == c_IDX_LAST) begin
            r_cout  <= w_co;
            r_idx   <= '0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + c_IDX_W'(1);
          end
        end
        DONE: begin
          // start is ignored here; the next request is taken from IDLE.
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_idx   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule : nibble_serial_adder
`default_nettype wire
